bl_link_pipe: RTL and testbench
===============================

Name: bl_link_pipe

Overview:
- Producer side of link-register (X30) forwarding: carries the BL flag and PC+4 of each BL instruction from decode through the EX, MEM and WB pipeline stages.
- Drives the per-stage BL status and PC+4 values that the forwarding unit consumes (IDEX, EXMEM, MEMWB).
- Issues the X30 write-back request to the register file in WB.
- Sits alongside the main pipeline registers and obeys the same freeze, stall and flush controls.

Parameters:
- WIDTH, 64, datapath / PC width in bits.
- LINK_REG, 5'd30, register index written by BL.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- freeze  input  1  global hold: all stage registers keep their value.
- stall  input  1  load-use stall: bubble inserted into IDEX; EXMEM and MEMWB advance.
- flush  input  1  squash the instruction moving ID->EX (taken branch); bubble into IDEX.
- ID_BL  input  1  decoded instruction in ID is BL.
- ID_PC_p4  input  WIDTH  PC+4 of the ID instruction.
- IDEX_BL  output  1  BL flag, EX stage.
- IDEX_PC_p4  output  WIDTH  PC+4, EX stage.
- EXMEM_BL  output  1  BL flag, MEM stage.
- EXMEM_PC_p4  output  WIDTH  PC+4, MEM stage.
- MEMWB_BL  output  1  BL flag, WB stage.
- MEMWB_PC_p4  output  WIDTH  PC+4, WB stage.
- WB_link_we  output  1  register-file write enable for the link register.
- WB_link_addr  output  5  always LINK_REG.
- WB_link_data  output  WIDTH  value to write (MEMWB_PC_p4).
- link_inflight  output  2  count of BL flags set across IDEX, EXMEM and MEMWB (0-3).

Behaviour:
- Reset (reset=0, asynchronous): all stage BL flags and PC_p4 registers go to 0, so WB_link_we=0 and link_inflight=0. Outputs stay 0 while reset is held. On release, the first update happens at the next rising clock edge.
- Priority per rising edge: freeze > (flush | stall) > normal advance.
- freeze=1: every stage register holds, independent of stall and flush.
- freeze=0, normal advance:
  - IDEX <= {ID_BL, ID_PC_p4}
  - EXMEM <= IDEX
  - MEMWB <= EXMEM
- freeze=0, flush=1 or stall=1:
  - IDEX <= bubble (BL=0, PC_p4=0).
  - EXMEM <= IDEX and MEMWB <= EXMEM as in normal advance.
  - The ID instruction is not consumed; the upstream pipeline replays it.
- Bubble rule: any stage whose BL flag is 0 must hold PC_p4=0. A non-BL instruction entering IDEX loads PC_p4=0 regardless of ID_PC_p4, so a PC value only appears in a stage together with BL=1.
- Latency: BL in ID at edge N gives
  - IDEX_BL=1 after edge N
  - EXMEM_BL=1 after N+1
  - MEMWB_BL=1 after N+2
  - WB_link_we=1 during the cycle after N+2
  - assuming no freeze in between.
- Write-back outputs (combinational from the MEMWB register):
  - WB_link_we = MEMWB_BL
  - WB_link_addr = LINK_REG, constant
  - WB_link_data = MEMWB_PC_p4
- While freeze=1, WB_link_we stays asserted if MEMWB_BL=1. The register file tolerates the repeated write of the same value.
- link_inflight = IDEX_BL + EXMEM_BL + MEMWB_BL, combinational. Back-to-back BLs reach 3 with no overflow or wrap.
- Simultaneous stall and flush: treated as a single bubble into IDEX.
- Reset asserted mid-operation: in-flight BLs are discarded and no partial write-back occurs.
- All stage registers are a single flop bank per stage with no combinational path from inputs to outputs. WB outputs depend only on MEMWB state.

Decomposition:
- Shared package holds:
  - LINK_REG constant
  - typedef for the stage record {bl, pc_p4}
  - BUBBLE constant (all zero)
- One natural sub-module: bl_stage_reg. It is one record-wide register with async active-low reset, a hold enable and a bubble select.
- Instantiate bl_stage_reg three times (IDEX, EXMEM, MEMWB).
- The popcount and write-back assignments stay in the top level.

Test Plan:
1. Reset release, ID_BL=1, ID_PC_p4=64'h1004, no stall → IDEX_BL=1 (PC 0x1004) after edge 1, EXMEM_BL after edge 2, MEMWB_BL after edge 3. WB_link_we=1, addr=30, data=0x1004 for exactly one cycle. link_inflight steps 1,1,1,0.
2. Three consecutive BLs (PC_p4 0x2004, 0x2008, 0x200C) → link_inflight=3 in the cycle after edge 3. WB writes 0x2004, 0x2008, 0x200C on consecutive cycles.
3. BL in ID with stall=1 for one edge, then released → IDEX gets a bubble (BL=0, PC_p4=0) on the stalled edge and the BL enters IDEX on the next edge. MEMWB reaches the BL one cycle later than in scenario 1.
4. BL in IDEX (PC 0x3004), freeze=1 for 2 edges → all stages hold and IDEX_PC_p4 stays 0x3004. After the freeze drops, the BL advances one stage per edge.
5. ID_BL=1 with flush=1 → IDEX_BL=0 and IDEX_PC_p4=0. No write-back occurs within 4 following cycles.
6. BL in EXMEM, reset pulsed low mid-cycle (asynchronously) → all outputs 0 immediately, with no WB_link_we pulse after release. A non-BL with ID_PC_p4=0xDEAD yields IDEX_PC_p4=0.

Source files
------------

// File: rtl/bl_link_pipe_pkg.sv
// Shared types and constants for the BL link-register forwarding pipe.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bl_link_pipe_pkg;

    // Datapath / PC width carried by each stage record
    localparam int PC_W = 64;

    // Register index that BL writes (X30)
    localparam logic [4:0] LINK_REG_IDX = 5'd30;

    // One pipeline-stage record: BL flag plus its PC+4.
    // pc_p4 is only ever nonzero when bl is set.
    typedef struct packed {
        logic            bl;
        logic [PC_W-1:0] pc_p4;
    } stage_t;

    // Empty slot: no BL and no PC value
    localparam stage_t BUBBLE = '{bl: 1'b0, pc_p4: '0};

endpackage

// File: rtl/bl_link_pipe_stage_reg.sv
// One record-wide pipeline stage register with hold and bubble insertion.
// Latency: 1 cycle from d_i to q_o.
// Backpressure: hold_i freezes the contents; bubble_i loads an empty record.
module bl_stage_reg
    import bl_link_pipe_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold_i,
    input  logic   bubble_i,
    input  stage_t d_i,
    output stage_t q_o
);

    stage_t stage_q;
    stage_t stage_d;

    // Next value: hold wins over bubble, bubble wins over the incoming record
    always_comb begin
        stage_d = stage_q;
        if (!hold_i) begin
            stage_d = bubble_i ? BUBBLE : d_i;
        end
    end

    // Stage flop bank, cleared asynchronously so in-flight BLs are discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/bl_link_pipe.sv
// Carries the BL flag and PC+4 through EX/MEM/WB and requests the X30 write-back.
// Latency: ID -> IDEX 1 edge, -> EXMEM 2 edges, -> MEMWB/write-back 3 edges.
// Backpressure: freeze holds every stage; stall/flush put a bubble into IDEX only.
module bl_link_pipe
    import bl_link_pipe_pkg::*;
#(
    parameter int         WIDTH    = PC_W,
    parameter logic [4:0] LINK_REG = LINK_REG_IDX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freeze,
    input  logic             stall,
    input  logic             flush,
    input  logic             ID_BL,
    input  logic [WIDTH-1:0] ID_PC_p4,
    output logic             IDEX_BL,
    output logic [WIDTH-1:0] IDEX_PC_p4,
    output logic             EXMEM_BL,
    output logic [WIDTH-1:0] EXMEM_PC_p4,
    output logic             MEMWB_BL,
    output logic [WIDTH-1:0] MEMWB_PC_p4,
    output logic             WB_link_we,
    output logic [4:0]       WB_link_addr,
    output logic [WIDTH-1:0] WB_link_data,
    output logic [1:0]       link_inflight
);

    stage_t id_rec_d;
    stage_t idex_q;
    stage_t exmem_q;
    stage_t memwb_q;
    logic   idex_bubble;

    // A non-BL instruction enters as an empty record so PC values never
    // appear in a stage without their BL flag.
    always_comb begin
        id_rec_d = BUBBLE;
        if (ID_BL) begin
            id_rec_d.bl    = 1'b1;
            id_rec_d.pc_p4 = ID_PC_p4;
        end
    end

    // Load-use stall and taken-branch flush both leave IDEX empty; the
    // upstream pipeline replays the ID instruction.
    assign idex_bubble = stall | flush;

    bl_stage_reg u_idex (
        .clk      (clk),
        .rst_n    (reset),
        .hold_i   (freeze),
        .bubble_i (idex_bubble),
        .d_i      (id_rec_d),
        .q_o      (idex_q)
    );

    bl_stage_reg u_exmem (
        .clk      (clk),
        .rst_n    (reset),
        .hold_i   (freeze),
        .bubble_i (1'b0),
        .d_i      (idex_q),
        .q_o      (exmem_q)
    );

    bl_stage_reg u_memwb (
        .clk      (clk),
        .rst_n    (reset),
        .hold_i   (freeze),
        .bubble_i (1'b0),
        .d_i      (exmem_q),
        .q_o      (memwb_q)
    );

    // Per-stage status for the forwarding unit
    assign IDEX_BL     = idex_q.bl;
    assign IDEX_PC_p4  = idex_q.pc_p4;
    assign EXMEM_BL    = exmem_q.bl;
    assign EXMEM_PC_p4 = exmem_q.pc_p4;
    assign MEMWB_BL    = memwb_q.bl;
    assign MEMWB_PC_p4 = memwb_q.pc_p4;

    // Write-back request depends only on MEMWB; a frozen BL keeps re-writing
    // the same value, which the register file tolerates.
    assign WB_link_we   = memwb_q.bl;
    assign WB_link_addr = LINK_REG;
    assign WB_link_data = memwb_q.pc_p4;

    // Number of BLs in flight; at most 3, so 2 bits never wrap
    assign link_inflight = {1'b0, idex_q.bl} + {1'b0, exmem_q.bl} + {1'b0, memwb_q.bl};

endmodule

// File: tb/tb_bl_link_pipe.sv
module tb_bl_link_pipe;

    localparam int W = 64;
    localparam logic [63:0] IDLE_PC = 64'hBAD0;

    logic         clk = 1'b0;
    logic         reset;
    logic         freeze, stall, flush, id_bl;
    logic [W-1:0] id_pc;
    logic         idex_bl, exmem_bl, memwb_bl, wb_we;
    logic [W-1:0] idex_pc, exmem_pc, memwb_pc, wb_data;
    logic [4:0]   wb_addr;
    logic [1:0]   inflight;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bl_link_pipe dut (
        .clk           (clk),
        .reset         (reset),
        .freeze        (freeze),
        .stall         (stall),
        .flush         (flush),
        .ID_BL         (id_bl),
        .ID_PC_p4      (id_pc),
        .IDEX_BL       (idex_bl),
        .IDEX_PC_p4    (idex_pc),
        .EXMEM_BL      (exmem_bl),
        .EXMEM_PC_p4   (exmem_pc),
        .MEMWB_BL      (memwb_bl),
        .MEMWB_PC_p4   (memwb_pc),
        .WB_link_we    (wb_we),
        .WB_link_addr  (wb_addr),
        .WB_link_data  (wb_data),
        .link_inflight (inflight)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a 3-slot pipe of instructions; index 0 = EX, 2 = WB.
    // Empty slots are represented as bl=0 with pc=0.
    bit          m_bl[3];
    logic [63:0] m_pc[3];

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_bl[i] = 1'b0;
            m_pc[i] = '0;
        end
    endtask

    task automatic model_edge();
        if (!freeze) begin
            for (int i = 2; i > 0; i--) begin
                m_bl[i] = m_bl[i-1];
                m_pc[i] = m_pc[i-1];
            end
            m_bl[0] = id_bl && !stall && !flush;
            m_pc[0] = m_bl[0] ? id_pc : 64'd0;
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = int'(m_bl[0]) + int'(m_bl[1]) + int'(m_bl[2]);
        chk({tag, " idex_bl"},  64'(idex_bl),  64'(m_bl[0]));
        chk({tag, " idex_pc"},  idex_pc,       m_pc[0]);
        chk({tag, " exmem_bl"}, 64'(exmem_bl), 64'(m_bl[1]));
        chk({tag, " exmem_pc"}, exmem_pc,      m_pc[1]);
        chk({tag, " memwb_bl"}, 64'(memwb_bl), 64'(m_bl[2]));
        chk({tag, " wb_we"},    64'(wb_we),    64'(m_bl[2]));
        chk({tag, " wb_data"},  wb_data,       m_pc[2]);
        chk({tag, " wb_addr"},  64'(wb_addr),  64'd30);
        chk({tag, " inflight"}, 64'(inflight), 64'(n));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " idex_bl"},  64'(idex_bl),  64'd0);
        chk({tag, " idex_pc"},  idex_pc,       64'd0);
        chk({tag, " exmem_bl"}, 64'(exmem_bl), 64'd0);
        chk({tag, " exmem_pc"}, exmem_pc,      64'd0);
        chk({tag, " memwb_bl"}, 64'(memwb_bl), 64'd0);
        chk({tag, " memwb_pc"}, memwb_pc,      64'd0);
        chk({tag, " wb_we"},    64'(wb_we),    64'd0);
        chk({tag, " inflight"}, 64'(inflight), 64'd0);
    endtask

    typedef struct {
        logic        fr, st, fl, bl;
        logic [63:0] pc;
        logic        e_ib;
        logic [63:0] e_ipc;
        logic        e_eb;
        logic [63:0] e_epc;
        logic        e_mb;
        logic [63:0] e_mpc;
        int          e_n;
    } vec_t;

    function automatic vec_t mk(logic fr, logic st, logic fl, logic bl, logic [63:0] pc,
                                logic ib, logic [63:0] ipc, logic eb, logic [63:0] epc,
                                logic mb, logic [63:0] mpc, int n);
        vec_t v;
        v.fr = fr; v.st = st; v.fl = fl; v.bl = bl; v.pc = pc;
        v.e_ib = ib; v.e_ipc = ipc; v.e_eb = eb; v.e_epc = epc;
        v.e_mb = mb; v.e_mpc = mpc; v.e_n = n;
        return v;
    endfunction

    function automatic vec_t idle(int n_unused);
        return mk(0, 0, 0, 0, IDLE_PC, 0, 0, 0, 0, 0, 0, n_unused);
    endfunction

    vec_t vt[32];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        string tag;
        // Directed table: inputs for one edge, then expected stage contents after it
        vt[0]  = mk(0,0,0,1,64'h1004, 1,64'h1004, 0,0,          0,0,          1);
        vt[1]  = mk(0,0,0,0,IDLE_PC,  0,0,        1,64'h1004,   0,0,          1);
        vt[2]  = mk(0,0,0,0,IDLE_PC,  0,0,        0,0,          1,64'h1004,   1);
        vt[3]  = idle(0);
        vt[4]  = mk(0,0,0,1,64'h2004, 1,64'h2004, 0,0,          0,0,          1);
        vt[5]  = mk(0,0,0,1,64'h2008, 1,64'h2008, 1,64'h2004,   0,0,          2);
        vt[6]  = mk(0,0,0,1,64'h200C, 1,64'h200C, 1,64'h2008,   1,64'h2004,   3);
        vt[7]  = mk(0,0,0,0,IDLE_PC,  0,0,        1,64'h200C,   1,64'h2008,   2);
        vt[8]  = mk(0,0,0,0,IDLE_PC,  0,0,        0,0,          1,64'h200C,   1);
        vt[9]  = idle(0);
        vt[10] = mk(0,1,0,1,64'h4004, 0,0,        0,0,          0,0,          0);
        vt[11] = mk(0,0,0,1,64'h4004, 1,64'h4004, 0,0,          0,0,          1);
        vt[12] = mk(0,0,0,0,IDLE_PC,  0,0,        1,64'h4004,   0,0,          1);
        vt[13] = mk(0,0,0,0,IDLE_PC,  0,0,        0,0,          1,64'h4004,   1);
        vt[14] = idle(0);
        vt[15] = mk(0,0,0,1,64'h3004, 1,64'h3004, 0,0,          0,0,          1);
        vt[16] = mk(1,0,0,1,64'h5004, 1,64'h3004, 0,0,          0,0,          1);
        vt[17] = mk(1,1,1,1,64'h5004, 1,64'h3004, 0,0,          0,0,          1);
        vt[18] = mk(0,0,0,0,IDLE_PC,  0,0,        1,64'h3004,   0,0,          1);
        vt[19] = mk(0,0,0,0,IDLE_PC,  0,0,        0,0,          1,64'h3004,   1);
        vt[20] = idle(0);
        vt[21] = mk(0,0,0,1,64'h6004, 1,64'h6004, 0,0,          0,0,          1);
        vt[22] = mk(0,0,0,0,IDLE_PC,  0,0,        1,64'h6004,   0,0,          1);
        vt[23] = mk(0,0,0,0,IDLE_PC,  0,0,        0,0,          1,64'h6004,   1);
        vt[24] = mk(1,0,0,0,IDLE_PC,  0,0,        0,0,          1,64'h6004,   1);
        vt[25] = idle(0);
        vt[26] = mk(0,0,1,1,64'h7004, 0,0,        0,0,          0,0,          0);
        vt[27] = mk(0,1,1,1,64'h7004, 0,0,        0,0,          0,0,          0);
        for (int i = 28; i < 32; i++) vt[i] = idle(0);

        // Reset state, held across edges
        reset = 1'b0; freeze = 0; stall = 0; flush = 0; id_bl = 1'b1; id_pc = 64'h1234;
        #1;
        check_zero("reset_async");
        chk("reset wb_addr", 64'(wb_addr), 64'd30);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_held");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            freeze = vt[i].fr; stall = vt[i].st; flush = vt[i].fl;
            id_bl  = vt[i].bl; id_pc = vt[i].pc;
            @(posedge clk);
            #1;
            tag = $sformatf("vec%0d", i);
            chk({tag, " idex_bl"},  64'(idex_bl),  64'(vt[i].e_ib));
            chk({tag, " idex_pc"},  idex_pc,       vt[i].e_ipc);
            chk({tag, " exmem_bl"}, 64'(exmem_bl), 64'(vt[i].e_eb));
            chk({tag, " exmem_pc"}, exmem_pc,      vt[i].e_epc);
            chk({tag, " wb_we"},    64'(wb_we),    64'(vt[i].e_mb));
            chk({tag, " wb_data"},  wb_data,       vt[i].e_mpc);
            chk({tag, " wb_addr"},  64'(wb_addr),  64'd30);
            chk({tag, " inflight"}, 64'(inflight), 64'(vt[i].e_n));
        end

        // Asynchronous reset with a BL sitting in EXMEM
        freeze = 0; stall = 0; flush = 0;
        id_bl = 1'b1; id_pc = 64'h8004;
        @(posedge clk);
        #1;
        id_bl = 1'b0; id_pc = 64'hDEAD;
        @(posedge clk);
        #1;
        chk("rst6 pre exmem_bl", 64'(exmem_bl), 64'd1);
        chk("rst6 pre exmem_pc", exmem_pc, 64'h8004);
        #2;
        reset = 1'b0;
        #1;
        check_zero("rst6 immediate");
        @(posedge clk);
        #1;
        check_zero("rst6 held");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            tag = $sformatf("rst6 post%0d", i);
            chk({tag, " wb_we"},    64'(wb_we),    64'd0);
            chk({tag, " idex_pc"},  idex_pc,       64'd0);
            chk({tag, " inflight"}, 64'(inflight), 64'd0);
        end

        // Randomized traffic against the reference model
        model_clear();
        for (int c = 0; c < 600; c++) begin
            freeze = ($urandom_range(0, 5) == 0);
            stall  = ($urandom_range(0, 4) == 0);
            flush  = ($urandom_range(0, 5) == 0);
            id_bl  = ($urandom_range(0, 1) == 1);
            id_pc  = {$urandom, $urandom};
            @(posedge clk);
            model_edge();
            #1;
            check_model($sformatf("rand%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
